f_d_pipe_reg: RTL and testbench
===============================

Name: f_d_pipe_reg

Overview:
- Fetch/Decode pipeline register; sits directly downstream of the PC register and instruction memory.
- Captures the fetched PC, instruction word and delay-slot flag each cycle.
- Detects fetch-address exceptions (AdEL) and converts a faulting fetch into a nop carrying the exception code.
- Supports stall (hold), flush (bubble) and exception request (redirect to the handler bubble), so the Decode stage always sees a well-defined macroscopic PC.

Parameters:
- RESET_PC, 32'h00003000, D_PC value after reset.
- HANDLER_PC, 32'h00004180, D_PC value loaded on exception request.
- IM_BASE, 32'h00003000, lowest legal fetch address.
- IM_END, 32'h00006ffc, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, exception code for an illegal fetch address.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- Req  in  1  exception/interrupt request from CP0; the register takes the handler bubble.
- Stall  in  1  hazard stall; the register holds its contents.
- Flush  in  1  discard the fetched instruction (e.g. eret in D); loads a bubble.
- F_PC  in  32  PC of the instruction being fetched.
- F_Instr  in  32  instruction word read from IM at F_PC.
- F_BD  in  1  fetched instruction is in a branch/jump delay slot.
- D_PC  out  32  registered PC.
- D_Instr  out  32  registered instruction; 0 (nop) when a bubble or faulting fetch.
- D_ExcCode  out  5  registered fetch exception code; 0 = none.
- D_BD  out  1  registered delay-slot flag.
- D_Valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- All state updates occur on the rising edge of clk. There is no combinational path from inputs to outputs.
- Reset state: D_PC = RESET_PC; D_Instr = 0; D_ExcCode = 0; D_BD = 0; D_Valid = 0.
- Update priority per edge: reset > Req > Stall > Flush > normal load.
- Req: D_PC = HANDLER_PC; D_Instr = 0; D_ExcCode = 0; D_BD = 0; D_Valid = 0. Req overrides Stall and Flush in the same cycle.
- Stall (Req = 0): all outputs hold. Stall overrides Flush, so an eret held in D does not kill its successor.
- Flush (Req = 0, Stall = 0): D_PC = F_PC; D_Instr = 0; D_ExcCode = 0; D_BD = 0; D_Valid = 0.
- Normal load: D_PC = F_PC; D_BD = F_BD; D_Valid = 1.
  - Fetch fault when F_PC[1:0] != 0, or F_PC < IM_BASE, or F_PC > IM_END. Comparisons are unsigned, 32-bit.
  - On fault: D_Instr = 0 and D_ExcCode = EXC_ADEL.
  - Otherwise: D_Instr = F_Instr and D_ExcCode = 0.
- Boundary addresses: F_PC = IM_BASE and F_PC = IM_END are legal. IM_END + 4 faults. 32'hfffffffc faults; no wrap-around acceptance.
- A faulting fetch still has D_Valid = 1, so the exception is reported at D_PC downstream.
- Latency: exactly one cycle from F_* to D_* when not stalled.
- A stalled register is not affected by changes on F_* during the stall.
- Reset asserted mid-stall or mid-flush returns the register to the reset state on the next edge, regardless of the other inputs.

Test Plan:
- Reset then normal load: reset=1 for 2 cycles, then F_PC=0x3000, F_Instr=0x3c010001, F_BD=0 → next edge D_PC=0x3000, D_Instr=0x3c010001, D_ExcCode=0, D_Valid=1.
- Stall hold: load F_PC=0x3004, then Stall=1 for 3 cycles while F_PC changes to 0x3008 → D_PC stays 0x3004 with all outputs unchanged; Stall=0 → D_PC=0x3008 next edge.
- Fetch faults:
  - F_PC=0x3002 → D_Instr=0, D_ExcCode=4, D_PC=0x3002, D_Valid=1.
  - F_PC=0x7000 → same response.
  - F_PC=0x6ffc with F_Instr=0x00000000 → D_ExcCode=0.
  - F_PC=0x2ffc → D_ExcCode=4.
- Flush vs Stall: Flush=1, Stall=0, F_PC=0x3010 → D_PC=0x3010, D_Instr=0, D_Valid=0. Flush=1, Stall=1 → outputs hold.
- Exception request: Req=1 together with Stall=1 and a faulting F_PC=0x3001 → D_PC=0x4180, D_Instr=0, D_ExcCode=0, D_BD=0, D_Valid=0.
- Delay slot plus reset priority: F_BD=1, F_PC=0x3020 → D_BD=1. Then reset=1 with Req=1 → D_PC=0x3000 and D_BD=0.

Source files
------------

// File: rtl/f_d_pipe_reg.sv
// Fetch/Decode pipeline register: captures PC, instruction and delay-slot flag, converting bad fetch addresses to AdEL nops.
// Latency: one cycle from F_* to D_*, with no combinational input-to-output path.
// Backpressure: Stall holds every output; Req and Flush load bubbles instead of the fetched word.
module f_d_pipe_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_END     = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    input  logic        F_BD,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD,
    output logic        D_Valid
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc_code;
        logic        bd;
        logic        vld;
    } d_stage_t;

    d_stage_t stage_q;
    d_stage_t stage_d;
    logic     fetch_fault;

    // Unsigned bounds check; an address past IM_END never wraps back into range.
    always_comb begin
        fetch_fault = (F_PC[1:0] != 2'b00) || (F_PC < IM_BASE) || (F_PC > IM_END);
    end

    always_comb begin
        stage_d = stage_q;
        if (Req) begin
            stage_d.pc       = HANDLER_PC;
            stage_d.instr    = 32'h0;
            stage_d.exc_code = 5'd0;
            stage_d.bd       = 1'b0;
            stage_d.vld      = 1'b0;
        end else if (Stall) begin
            // Stall wins over Flush so an eret held in D does not kill its successor.
            stage_d = stage_q;
        end else if (Flush) begin
            stage_d.pc       = F_PC;
            stage_d.instr    = 32'h0;
            stage_d.exc_code = 5'd0;
            stage_d.bd       = 1'b0;
            stage_d.vld      = 1'b0;
        end else begin
            stage_d.pc       = F_PC;
            stage_d.bd       = F_BD;
            stage_d.vld      = 1'b1;
            stage_d.instr    = fetch_fault ? 32'h0 : F_Instr;
            stage_d.exc_code = fetch_fault ? EXC_ADEL : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q.pc       <= RESET_PC;
            stage_q.instr    <= 32'h0;
            stage_q.exc_code <= 5'd0;
            stage_q.bd       <= 1'b0;
            stage_q.vld      <= 1'b0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign D_PC      = stage_q.pc;
    assign D_Instr   = stage_q.instr;
    assign D_ExcCode = stage_q.exc_code;
    assign D_BD      = stage_q.bd;
    assign D_Valid   = stage_q.vld;

endmodule

// File: tb/tb_f_d_pipe_reg.sv
// Directed bench for f_d_pipe_reg: stimulus queues hand-computed expectations, a monitor checks them after each edge.
module tb_f_d_pipe_reg;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        Stall;
    logic        Flush;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_BD;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;
    logic        D_Valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        vld;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   step_no;

    f_d_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .Stall     (Stall),
        .Flush     (Flush),
        .F_PC      (F_PC),
        .F_Instr   (F_Instr),
        .F_BD      (F_BD),
        .D_PC      (D_PC),
        .D_Instr   (D_Instr),
        .D_ExcCode (D_ExcCode),
        .D_BD      (D_BD),
        .D_Valid   (D_Valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one vector at the falling edge and queue what must appear after the next rising edge.
    task automatic step(input logic r, input logic rq, input logic st, input logic fl,
                        input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [4:0] e_exc, input logic e_bd, input logic e_vld);
        exp_t e;
        @(negedge clk);
        reset   = r;
        Req     = rq;
        Stall   = st;
        Flush   = fl;
        F_PC    = pc;
        F_Instr = instr;
        F_BD    = bd;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.exc   = e_exc;
        e.bd    = e_bd;
        e.vld   = e_vld;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        step_no = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step_no++;
                checks++;
                if ({D_PC, D_Instr, D_ExcCode, D_BD, D_Valid} !== e) begin
                    errors++;
                    $display("FAIL step%0d: got pc=%h instr=%h exc=%0d bd=%b vld=%b, want pc=%h instr=%h exc=%0d bd=%b vld=%b",
                             step_no, D_PC, D_Instr, D_ExcCode, D_BD, D_Valid,
                             e.pc, e.instr, e.exc, e.bd, e.vld);
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        Req     = 1'b0;
        Stall   = 1'b0;
        Flush   = 1'b0;
        F_PC    = 32'h0;
        F_Instr = 32'h0;
        F_BD    = 1'b0;

        //    rst  req  stl  fls  F_PC           F_Instr        BD    D_PC           D_Instr        Exc   BD    Vld
        // reset for two cycles
        step(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0, 32'h0000_3000,32'h0000_0000,5'd0,1'b0,1'b0);
        step(1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0, 32'h0000_3000,32'h0000_0000,5'd0,1'b0,1'b0);
        // normal loads
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3000,32'h3c01_0001,1'b0, 32'h0000_3000,32'h3c01_0001,5'd0,1'b0,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3004,32'h2401_0002,1'b0, 32'h0000_3004,32'h2401_0002,5'd0,1'b0,1'b1);
        // stall for three cycles while F_* moves on
        step(1'b0,1'b0,1'b1,1'b0,32'h0000_3008,32'h1111_1111,1'b1, 32'h0000_3004,32'h2401_0002,5'd0,1'b0,1'b1);
        step(1'b0,1'b0,1'b1,1'b0,32'h0000_3008,32'h1111_1111,1'b1, 32'h0000_3004,32'h2401_0002,5'd0,1'b0,1'b1);
        step(1'b0,1'b0,1'b1,1'b0,32'h0000_3001,32'h2222_2222,1'b0, 32'h0000_3004,32'h2401_0002,5'd0,1'b0,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3008,32'h1111_1111,1'b0, 32'h0000_3008,32'h1111_1111,5'd0,1'b0,1'b1);
        // fetch faults and address boundaries
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3002,32'hdead_beef,1'b0, 32'h0000_3002,32'h0000_0000,5'd4,1'b0,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_7000,32'hdead_beef,1'b0, 32'h0000_7000,32'h0000_0000,5'd4,1'b0,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_6ffc,32'h0000_0000,1'b0, 32'h0000_6ffc,32'h0000_0000,5'd0,1'b0,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_2ffc,32'h0000_abcd,1'b0, 32'h0000_2ffc,32'h0000_0000,5'd4,1'b0,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'hffff_fffc,32'h0000_abcd,1'b1, 32'hffff_fffc,32'h0000_0000,5'd4,1'b1,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_6ffc,32'h1234_5678,1'b1, 32'h0000_6ffc,32'h1234_5678,5'd0,1'b1,1'b1);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_6ffe,32'h1234_5678,1'b0, 32'h0000_6ffe,32'h0000_0000,5'd4,1'b0,1'b1);
        // flush, then flush with stall
        step(1'b0,1'b0,1'b0,1'b1,32'h0000_3010,32'h0000_0055,1'b1, 32'h0000_3010,32'h0000_0000,5'd0,1'b0,1'b0);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3014,32'h0000_0066,1'b0, 32'h0000_3014,32'h0000_0066,5'd0,1'b0,1'b1);
        step(1'b0,1'b0,1'b1,1'b1,32'h0000_3018,32'h0000_0077,1'b1, 32'h0000_3014,32'h0000_0066,5'd0,1'b0,1'b1);
        // exception request beats stall and flush
        step(1'b0,1'b1,1'b1,1'b0,32'h0000_3001,32'h0000_0088,1'b1, 32'h0000_4180,32'h0000_0000,5'd0,1'b0,1'b0);
        step(1'b0,1'b1,1'b0,1'b1,32'h0000_3000,32'h0000_0099,1'b1, 32'h0000_4180,32'h0000_0000,5'd0,1'b0,1'b0);
        // delay slot, then reset beats Req
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3020,32'h0000_00aa,1'b1, 32'h0000_3020,32'h0000_00aa,5'd0,1'b1,1'b1);
        step(1'b1,1'b1,1'b0,1'b0,32'h0000_3024,32'h0000_00bb,1'b1, 32'h0000_3000,32'h0000_0000,5'd0,1'b0,1'b0);
        // reset while stalled
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3028,32'h0000_00cc,1'b1, 32'h0000_3028,32'h0000_00cc,5'd0,1'b1,1'b1);
        step(1'b1,1'b0,1'b1,1'b1,32'h0000_302c,32'h0000_00dd,1'b1, 32'h0000_3000,32'h0000_0000,5'd0,1'b0,1'b0);
        step(1'b0,1'b0,1'b0,1'b0,32'h0000_3030,32'h0000_00ee,1'b0, 32'h0000_3030,32'h0000_00ee,5'd0,1'b0,1'b1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
